// File: rtl/chunked_serial_adder.sv
// -----------------------------------------------------------------------------
// chunked_serial_adder
//
// Multi-cycle unsigned adder. The operands are latched on a valid/ready
// handshake. They are added CHUNK bits per clock, and the carry between chunks
// is held in a register. The result is then offered on a second valid/ready
// handshake. This keeps the carry chain CHUNK bits long, at the cost of
// NCHUNK = WIDTH/CHUNK add cycles per operation.
//
// Optional build macro: CHUNKED_ADDER_SUB_EN
//   When it is defined, a 'sub' input is present. With sub=1 the block computes
//   a + ~b + 1 and ignores cin, so cout=1 means "no borrow" (a >= b).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; aborts any operation in flight
//   in_valid   operand set offered
//   in_ready   block is idle and can accept operands
//   a, b       WIDTH-bit operands
//   cin        carry in
//   sub        (CHUNKED_ADDER_SUB_EN only) subtract select
//   out_valid  result available in sum/cout
//   out_ready  consumer takes the result
//   sum        WIDTH-bit result; it updates chunk by chunk while adding, so
//              qualify it with out_valid
//   cout       carry out of the MSB
// -----------------------------------------------------------------------------
module chunked_serial_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic [CHUNK-1:0] chunk_a;
   logic [CHUNK-1:0] chunk_b;
   logic [CHUNK:0]   chunk_sum;
   logic             do_sub;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      chunk_a = '0;
      chunk_b = '0;

`ifdef CHUNKED_ADDER_SUB_EN
      do_sub = sub;
`else
      do_sub = 1'b0;
`endif

      // Select the chunk pointed to by k_q. This is a constant-index mux, so
      // the slice bounds never depend on a runtime multiply.
      for (int i = 0; i < NCHUNK; i++) begin
         if (k_q == KW'(i)) begin
            chunk_a = a_q[i*CHUNK +: CHUNK];
            chunk_b = b_q[i*CHUNK +: CHUNK];
         end
      end
      chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               // Subtraction is folded in at latch time: store ~b and
               // preload the carry with 1. The ADD loop stays the same.
               b_d     = do_sub ? ~b : b;
               carry_d = do_sub ? 1'b1 : cin;
               k_d     = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            carry_d = chunk_sum[CHUNK];
            for (int i = 0; i < NCHUNK; i++) begin
               if (k_q == KW'(i)) begin
                  sum_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
               end
            end
            if (k_q == K_LAST) begin
               cout_d  = chunk_sum[CHUNK];
               state_d = DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
module tb_chunked_serial_adder;

   localparam int W   = 16;
   localparam int C   = 4;
   localparam int NCH = W / C;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;

   // 16-bit / 4-bit-chunk instance
   logic         iv16 = 1'b0, or16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
   logic         ir16, ov16, cout16;
   logic [W-1:0] a16 = '0, b16 = '0, sum16;

   // 4-bit single-chunk instance
   logic         iv4 = 1'b0, or4 = 1'b0, cin4 = 1'b0;
   logic         ir4, ov4, cout4;
   logic [3:0]   a4 = '0, b4 = '0, sum4;
`ifdef CHUNKED_ADDER_SUB_EN
   logic         sub4 = 1'b0;
`endif

   chunked_serial_adder #(.WIDTH(W), .CHUNK(C)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
      .a(a16), .b(b16), .cin(cin16),
`ifdef CHUNKED_ADDER_SUB_EN
      .sub(sub16),
`endif
      .out_valid(ov16), .out_ready(or16), .sum(sum16), .cout(cout16)
   );

   chunked_serial_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
      .a(a4), .b(b4), .cin(cin4),
`ifdef CHUNKED_ADDER_SUB_EN
      .sub(sub4),
`endif
      .out_valid(ov4), .out_ready(or4), .sum(sum4), .cout(cout4)
   );

   int total  = 0;
   int passed = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   // Transaction-level reference: the arithmetic result, plus the number of
   // edges left before it is presented.
   function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci, input logic s);
      if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
      else   return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
   endfunction

   bit         m_busy = 1'b0;
   int         m_cnt  = 0;
   logic [W:0] m_res  = '0;
   logic [W:0] m_ret  = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_cnt  <= 0;
         m_res  <= '0;
         m_ret  <= '0;
      end else if (!m_busy) begin
         if (iv16) begin
            m_busy <= 1'b1;
            m_cnt  <= NCH;
            m_res  <= ref_result(a16, b16, cin16, sub16);
         end
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) m_ret <= m_res;
      end else if (or16) begin
         m_busy <= 1'b0;
      end
   end

   // Per-cycle compare for the 16-bit instance. The sum is not checked while
   // the add is in progress, because it is only partly written then.
   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", ir16, !m_busy);
         check("out_valid", ov16, (m_busy && m_cnt == 0));
         if (!m_busy || m_cnt == 0)
            check("cout_sum", {cout16, sum16}, m_ret);
      end
   end

   task automatic op16(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       input logic s, output int lat);
      @(negedge clk);
      a16 = x; b16 = y; cin16 = ci; sub16 = s; iv16 = 1'b1; or16 = 1'b0;
      @(posedge clk);
      lat = 1;                       // the accepting edge counts as edge 1
      @(negedge clk);
      iv16 = 1'b0;
      while (!ov16 && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic release16();
      or16 = 1'b1;
      @(negedge clk);
      or16 = 1'b0;
   endtask

   task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic ci, output int lat);
      @(negedge clk);
      a4 = x; b4 = y; cin4 = ci; iv4 = 1'b1; or4 = 1'b0;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      iv4 = 1'b0;
      while (!ov4 && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n_done;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset in_ready", ir16, 1);
      check("reset out_valid", ov16, 0);
      check("reset sum", sum16, 0);
      check("reset cout", cout16, 0);
      check("reset in_ready w4", ir4, 1);
      chk_en = 1'b1;

      // Single-chunk instance: a=b=i gives 2*i, with the result on edge 2
      // counting the accepting edge.
      for (int i = 0; i < 16; i++) begin
         op4(4'(i), 4'(i), 1'b0, lat);
         check("w4 latency", lat, 2);
         check("w4 result", {cout4, sum4}, 32'(2 * i));
         if (i == 15) begin
            check("w4 i15 cout", cout4, 1);
            check("w4 i15 sum", sum4, 32'hE);
         end
         or4 = 1'b1;
         @(negedge clk);
         or4 = 1'b0;
      end

      // The carry ripples through all four chunks.
      op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
      check("ripple latency", lat, NCH + 1);
      check("ripple sum", sum16, 32'h0000);
      check("ripple cout", cout16, 1);
      release16();

      // Backpressure: DONE holds and the outputs stay frozen.
      op16(16'h1234, 16'h4321, 1'b1, 1'b0, lat);
      for (int i = 0; i < 10; i++) begin
         a16 = W'($urandom); b16 = W'($urandom); iv16 = 1'b1;
         @(negedge clk);
         check("hold sum", sum16, 32'h5556);
         check("hold cout", cout16, 0);
         check("hold in_ready", ir16, 0);
         check("hold out_valid", ov16, 1);
      end
      iv16 = 1'b0;
      or16 = 1'b1;
      @(negedge clk);
      or16 = 1'b0;
      check("release out_valid", ov16, 0);
      check("release in_ready", ir16, 1);

      // Reset during the second ADD cycle.
      @(negedge clk);
      a16 = 16'h00F0; b16 = 16'h0F0F; cin16 = 1'b0; iv16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv16 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort out_valid", ov16, 0);
      check("abort in_ready", ir16, 1);
      check("abort sum", sum16, 0);
      check("abort cout", cout16, 0);
      op16(16'h0003, 16'h0004, 1'b0, 1'b0, lat);
      check("after abort sum", sum16, 32'h0007);
      check("after abort cout", cout16, 0);
      release16();

      // Streaming: in_valid and out_ready held high, operands churning.
      n_done = 0;
      or16 = 1'b1;
      iv16 = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ov16 && or16) n_done++;
         a16 = W'($urandom); b16 = W'($urandom); cin16 = 1'($urandom);
      end
      check("stream results", (n_done >= 5), 1);
      iv16 = 1'b0;
      repeat (NCH + 3) @(negedge clk);

      // Random traffic with random backpressure.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         iv16  = 1'($urandom_range(0, 1));
         a16   = W'($urandom);
         b16   = W'($urandom);
         cin16 = 1'($urandom);
         or16  = ($urandom_range(0, 3) != 0);
`ifdef CHUNKED_ADDER_SUB_EN
         sub16 = 1'($urandom);
`endif
      end
      iv16 = 1'b0;
      or16 = 1'b1;
      repeat (NCH + 3) @(negedge clk);
      or16 = 1'b0;
      sub16 = 1'b0;

`ifdef CHUNKED_ADDER_SUB_EN
      op16(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
      check("sub 5-7 sum", sum16, 32'hFFFE);
      check("sub 5-7 cout", cout16, 0);
      release16();
      op16(16'h0007, 16'h0005, 1'b1, 1'b1, lat);
      check("sub 7-5 sum", sum16, 32'h0002);
      check("sub 7-5 cout", cout16, 1);
      release16();
      sub16 = 1'b0;
`endif

      @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
